fp5_encode: RTL and testbench
=============================

# fp5_encode

Streaming converter from signed two's-complement fixed-point to the 5-bit floating-point format consumed by `fpadd` (sign, 3-bit exponent, 1 explicit mantissa bit, hidden leading one). It is the producer side of the MAC datapath: it quantises fixed-point activations or weights into fp5 operands. It is a 2-stage valid/ready pipeline with round-to-nearest-even, saturation and zero/underflow flagging.

## Interface
- `IN_W`, 8: input word width; legal range 4..16.
- `FRAC_W`, 4: number of fractional bits in the input; legal range 0..IN_W-1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  IN_W  signed fixed-point value.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `out_data`  out  5  fp5 word `{s, e[2:0], m}`.
- `out_zero`  out  1  the result is zero; `out_data` is 5'b00000.
- `out_ovf`  out  1  the result saturated to the maximum magnitude.
- `out_uf`  out  1  a nonzero input flushed to zero.
- `out_valid`  out  1  the output fields are valid.
- `out_ready`  in  1  the downstream stage accepts the output.
- `ovf_cnt`  out  8  saturating count of `out_ovf` transfers.
- `uf_cnt`  out  8  saturating count of `out_uf` transfers.

## Operation
- **fp5 value:** (-1)^s × (1 + m/2) × 2^(e−3); bias is 3. Representable magnitudes run from 0.125 to 24.
- **Stage 1 (capture):**
  - register the sign.
  - register the magnitude |x| as IN_W-bit unsigned. The most-negative input maps to 2^(IN_W−1) without overflow.
  - register the leading-one index `p`, or a zero indicator when the magnitude is 0.
- **Stage 2 (round and pack):**
  - Unbiased exponent E = p − FRAC_W.
  - Mantissa bit = magnitude[p−1], or 0 when p = 0.
  - Guard bit = magnitude[p−2]; sticky = OR of magnitude[p−3:0]. Missing bits read as 0.
  - Round up when guard & (sticky | mantissa).
  - If the round-up carries out of the mantissa, set mantissa to 0 and increment E.
  - Biased exponent B = E + 3.
- **Result selection**, in priority order:
  - Zero input: `out_data` = 5'b00000, `out_zero` = 1, `out_uf` = 0.
  - B < 0: `out_data` = 5'b00000, `out_zero` = 1, `out_uf` = 1.
  - B > 7: `out_data` = {s, 3'b111, 1'b1}, `out_ovf` = 1.
  - Otherwise: `out_data` = {s, B[2:0], mantissa}.
- **Flags:** `out_zero`, `out_ovf` and `out_uf` are mutually exclusive.
- **Handshake:**
  - A transfer occurs when valid & ready are both high in the same cycle, at each boundary.
  - Each stage advances when it is empty or when the stage after it advances.
  - `in_ready` = !s1_valid | s2_advance, where s2_advance = !out_valid | out_ready. `in_ready` is combinational from `out_ready`.
  - Output fields hold stable while `out_valid` & !`out_ready`.
  - No data is dropped or duplicated under any backpressure pattern.

## Timing
- **Latency:** 2 cycles. Data accepted at edge N is presented after edge N+1 and can transfer at edge N+2.
- **Throughput:** 1 word per cycle while `out_ready` = 1.
- **Buffering:** with `out_ready` held low, the block holds at most 2 words. `in_ready` falls in the cycle after the second accept.
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, all flags = 0, both counters = 0.
  - `in_ready` = 1 after reset.
  - An assertion of `rst` mid-stream discards both in-flight words immediately.
- **Counters:**
  - A counter increments only on an output transfer whose corresponding flag is set.
  - A counter holds at 8'hFF and never wraps.

## Configuration
- `FP5ENC_STATS_EN` defined: `ovf_cnt` and `uf_cnt` are implemented as described above.
- `FP5ENC_STATS_EN` undefined: no counter registers are built, and both ports are tied to 8'h00. The datapath and flags are unchanged.

## Test plan
- **Basic encodes** (defaults): in 0x18 (1.5) → 5'b00111 two cycles later; 0xE0 (−2.0) → 5'b11000.
- **Rounding:**
  - 0x14 (1.25, tie with even mantissa) → 5'b00110.
  - 0x1C (1.75, tie with odd mantissa) → 5'b01000.
  - 0x7F (7.9375) → 5'b01100 via mantissa carry.
  - 0x80 (−8) → 5'b11100.
- **Zero and underflow:** 0x00 → 5'b00000 with `out_zero` = 1, `out_uf` = 0. 0x01 (0.0625) → 5'b00000 with `out_zero` = 1, `out_uf` = 1, and `uf_cnt` increments.
- **Overflow** (FRAC_W = 0): in 100 → 5'b01111 with `out_ovf` = 1. Send 300 such words → `ovf_cnt` holds at 8'hFF. With the macro undefined, `ovf_cnt` stays 8'h00.
- **Backpressure:**
  - Drive `out_ready` = 0 and offer 0x18, 0xE0, 0x7F back-to-back → `in_ready` drops after the second accept.
  - Release `out_ready` → outputs 5'b00111, 5'b11000, then 5'b01100 once accepted, in order, with no loss.
  - Random valid/ready toggling over 1000 words matches a reference model.
- **Reset mid-stream:** assert `rst` with 2 words in flight → `out_valid` drops immediately. After release, `in_ready` = 1 and no stale word appears.

Source files
------------

// File: rtl/fp5_encode.sv
// fp5_encode: streaming fixed-point to fp5 quantiser.
//
// Converts a signed two's-complement fixed-point word (IN_W bits, FRAC_W of
// them fractional) into the 5-bit float {s, e[2:0], m} used by fpadd:
// value = (-1)^s * (1 + m/2) * 2^(e-3). Rounds to nearest, ties to even
// mantissa, saturates to +/-24 and flushes magnitudes below 0.125 to zero.
//
// Two-stage valid/ready pipeline:
//   stage 1 captures sign, |x| and the leading-one index,
//   stage 2 rounds, packs and classifies the result.
//
// Parameters:
//   IN_W    input word width (4..16)
//   FRAC_W  fractional bits of the input (0..IN_W-1)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    signed fixed-point input word
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle (combinational from out_ready)
//   out_data   fp5 result {s, e[2:0], m}
//   out_zero   result is zero (out_data = 0)
//   out_ovf    result saturated to maximum magnitude
//   out_uf     nonzero input flushed to zero
//   out_valid  output fields valid
//   out_ready  downstream accepts the output
//   ovf_cnt    saturating count of overflow transfers
//   uf_cnt     saturating count of underflow transfers
//
// Build option:
//   FP5ENC_STATS_EN  defined: ovf_cnt / uf_cnt counters are built.
//                    undefined: both counter ports read 8'h00.

module fp5_encode #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4:0]             out_data,
  output logic                   out_zero,
  output logic                   out_ovf,
  output logic                   out_uf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             ovf_cnt,
  output logic [7:0]             uf_cnt
);

  localparam int PW = $clog2(IN_W);

  // Result word layout: {data[4:0], zero, ovf, uf}.
  function automatic logic [7:0] round_pack(
    input logic            sign,
    input logic            zero,
    input logic [IN_W-1:0] mag,
    input logic [PW-1:0]   pos
  );
    logic [IN_W-2:0]  frac;
    logic             mant;
    logic             guard;
    logic             sticky;
    logic             up;
    logic             carry;
    logic signed [6:0] bexp;
    // Left-justify so the leading one would sit just above frac; bits
    // shifted in from below are zero, which covers missing guard/sticky bits.
    frac   = (IN_W-1)'(mag << (PW'(IN_W-1) - pos));
    mant   = frac[IN_W-2];
    guard  = frac[IN_W-3];
    sticky = |frac[IN_W-4:0];
    up     = guard & (sticky | mant);
    carry  = up & mant;
    mant   = mant ^ up;
    bexp   = 7'(pos) - 7'(FRAC_W) + 7'(3) + 7'(carry);
    if (zero)
      round_pack = {5'b00000, 3'b100};
    else if (bexp < 7'sd0)
      round_pack = {5'b00000, 3'b101};
    else if (bexp > 7'sd7)
      round_pack = {sign, 4'b1111, 3'b010};
    else
      round_pack = {sign, bexp[2:0], mant, 3'b000};
  endfunction

  logic [IN_W-1:0] w_mag;
  logic [PW-1:0]   w_pos;
  logic            w_zero;
  logic            w_s2_adv;
  logic [7:0]      w_res;

  logic            r_vld_p1;
  logic            r_sign_p1;
  logic [IN_W-1:0] r_mag_p1;
  logic [PW-1:0]   r_pos_p1;
  logic            r_zero_p1;

  logic            r_vld_p2;
  logic [4:0]      r_data_p2;
  logic            r_zero_p2;
  logic            r_ovf_p2;
  logic            r_uf_p2;

  // Negating the most-negative value yields 2^(IN_W-1), which fits unsigned.
  assign w_mag  = in_data[IN_W-1] ? $unsigned(-in_data) : $unsigned(in_data);
  assign w_zero = (in_data == '0);

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < IN_W; i++)
      if (w_mag[i]) w_pos = PW'(i);
  end

  assign w_s2_adv = !r_vld_p2 | out_ready;
  assign in_ready = !r_vld_p1 | w_s2_adv;

  // ---- stage 1: capture sign, magnitude, leading-one index ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_vld_p1 <= 1'b0;
    else if (in_ready)
      r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      r_sign_p1 <= in_data[IN_W-1];
      r_mag_p1  <= w_mag;
      r_pos_p1  <= w_pos;
      r_zero_p1 <= w_zero;
    end
  end

  assign w_res = round_pack(r_sign_p1, r_zero_p1, r_mag_p1, r_pos_p1);

  // ---- stage 2: round, pack, classify ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= 5'b00000;
      r_zero_p2 <= 1'b0;
      r_ovf_p2  <= 1'b0;
      r_uf_p2   <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= w_res[7:3];
        r_zero_p2 <= w_res[2];
        r_ovf_p2  <= w_res[1];
        r_uf_p2   <= w_res[0];
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_zero  = r_zero_p2;
  assign out_ovf   = r_ovf_p2;
  assign out_uf    = r_uf_p2;

`ifdef FP5ENC_STATS_EN
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_uf_cnt;
  logic       w_xfer;

  assign w_xfer = r_vld_p2 & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= 8'h00;
      r_uf_cnt  <= 8'h00;
    end else begin
      if (w_xfer && r_ovf_p2 && r_ovf_cnt != 8'hFF)
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      if (w_xfer && r_uf_p2 && r_uf_cnt != 8'hFF)
        r_uf_cnt <= r_uf_cnt + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign uf_cnt  = r_uf_cnt;
`else
  assign ovf_cnt = 8'h00;
  assign uf_cnt  = 8'h00;
`endif

endmodule

// File: tb/tb_fp5_encode.sv
// tb_fp5_encode: self-checking bench for fp5_encode.
// Main instance uses defaults (IN_W=8, FRAC_W=4); a second instance with
// FRAC_W=0 exercises overflow and counter saturation.

module tb_fp5_encode;

`ifdef FP5ENC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] d;
    logic       z;
    logic       o;
    logic       u;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] out_data;
  logic       out_zero, out_ovf, out_uf, out_valid;
  logic       out_ready;
  logic [7:0] ovf_cnt, uf_cnt;

  logic [7:0] b_in_data;
  logic       b_in_valid, b_in_ready;
  logic [4:0] b_out_data;
  logic       b_out_zero, b_out_ovf, b_out_uf, b_out_valid;
  logic       b_out_ready;
  logic [7:0] b_ovf_cnt, b_uf_cnt;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  exp_t cur_exp;
  int   exp_ovf_cnt = 0;
  int   exp_uf_cnt  = 0;
  bit   rr_en = 1'b0;

  always #5 clk = ~clk;

  fp5_encode #(.IN_W(8), .FRAC_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_uf(out_uf), .out_valid(out_valid), .out_ready(out_ready),
    .ovf_cnt(ovf_cnt), .uf_cnt(uf_cnt)
  );

  fp5_encode #(.IN_W(8), .FRAC_W(0)) u_dut_ovf (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_zero(b_out_zero), .out_ovf(b_out_ovf),
    .out_uf(b_out_uf), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .ovf_cnt(b_ovf_cnt), .uf_cnt(b_uf_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: nearest fp5 magnitude by exhaustive search, ties to even m.
  function automatic exp_t model(input logic [7:0] x);
    real  v, sc, c, d, bd;
    int   be, bm, b;
    logic s;
    exp_t r;
    s = x[7];
    if (x == 8'h00) return 8'b00000_100;
    v  = s ? (256.0 - real'(int'(x))) : real'(int'(x));
    v  = v / 16.0;
    bd = 1.0e9; be = 0; bm = 0;
    sc = 1.0 / 4096.0;
    for (int e = -12; e <= 12; e++) begin
      for (int m = 0; m < 2; m++) begin
        c = sc * (1.0 + 0.5 * m);
        d = (v > c) ? (v - c) : (c - v);
        if (d < bd || (d == bd && m == 0)) begin
          bd = d; be = e; bm = m;
        end
      end
      sc = sc * 2.0;
    end
    b = be + 3;
    if (b < 0)      r = 8'b00000_101;
    else if (b > 7) r = {s, 4'b1111, 3'b010};
    else            r = {s, 3'(b), 1'(bm), 3'b000};
    return r;
  endfunction

  // Scoreboard: push at accept, pop and compare at output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", 32'({out_data, out_zero, out_ovf, out_uf}), 32'(e));
          if (e.o && exp_ovf_cnt != 255) exp_ovf_cnt++;
          if (e.u && exp_uf_cnt != 255) exp_uf_cnt++;
        end
      end
    end
  end

  // Random out_ready while rr_en is set.
  always begin
    @(posedge clk);
    #1;
    if (rr_en) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic drive(input logic [7:0] d, input exp_t e);
    bit ok = 1'b0;
    in_data  = d;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(in_data), 32'hFFFF_FFFF);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    logic [7:0] rd;
    int cnt;
    bit seen;

    tbl[0]  = '{8'h18, 8'b00111_000};
    tbl[1]  = '{8'hE0, 8'b11000_000};
    tbl[2]  = '{8'h14, 8'b00110_000};
    tbl[3]  = '{8'h1C, 8'b01000_000};
    tbl[4]  = '{8'h7F, 8'b01100_000};
    tbl[5]  = '{8'h80, 8'b11100_000};
    tbl[6]  = '{8'h00, 8'b00000_100};
    tbl[7]  = '{8'h01, 8'b00000_101};
    tbl[8]  = '{8'hFF, 8'b00000_101};
    tbl[9]  = '{8'h02, 8'b00000_000};
    tbl[10] = '{8'hF0, 8'b10110_000};
    tbl[11] = '{8'h0C, 8'b00101_000};

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    cur_exp = '0;
    b_in_data = 8'd100; b_in_valid = 1'b0; b_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", 32'({out_zero, out_ovf, out_uf}), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_uf_cnt", 32'(uf_cnt), 32'd0);
    chk("rst_b_ovf_cnt", 32'(b_ovf_cnt), 32'd0);

    // Latency: accepted at edge N, visible after edge N+1.
    drive(8'h18, 8'b00111_000);
    chk("lat_after_n", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_after_n1_valid", 32'(out_valid), 32'd1);
    chk("lat_after_n1_data", 32'(out_data), 32'b00111);
    wait_drain("drain_lat");

    // Table vectors, back to back.
    for (int i = 0; i < 12; i++) drive(tbl[i].din, tbl[i].e);
    wait_drain("drain_table");
    chk("uf_cnt_table", 32'(uf_cnt), STATS ? 32'd2 : 32'd0);
    chk("ovf_cnt_table", 32'(ovf_cnt), 32'd0);

    // Overflow instance: one word, then 299 more streamed.
    b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (b_out_valid) seen = 1'b1;
    end
    chk("ovf_word", 32'({b_out_valid, b_out_data, b_out_zero, b_out_ovf, b_out_uf}),
        32'({1'b1, 5'b01111, 3'b010}));
    @(posedge clk);
    #1;
    chk("ovf_cnt_one", 32'(b_ovf_cnt), STATS ? 32'd1 : 32'd0);
    cnt = 0;
    b_in_valid = 1'b1;
    for (int i = 0; i < 1000 && cnt < 299; i++) begin
      @(negedge clk);
      if (b_in_ready) cnt++;
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_cnt_sat", 32'(b_ovf_cnt), STATS ? 32'hFF : 32'h00);
    chk("ovf_uf_cnt", 32'(b_uf_cnt), 32'd0);

    // Backpressure: two words fill the pipe, third waits.
    out_ready = 1'b0;
    drive(8'h18, 8'b00111_000);
    drive(8'hE0, 8'b11000_000);
    in_data = 8'h7F; cur_exp = 8'b01100_000; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'({out_valid, out_data, in_ready}), 32'({1'b1, 5'b00111, 1'b0}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(8'h7F, 8'b01100_000);
    wait_drain("drain_bp");

    // Random valid/ready over 1000 words against the reference model.
    rr_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      rd = 8'($urandom);
      drive(rd, model(rd));
    end
    rr_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain("drain_rand");
    chk("uf_cnt_rand", 32'(uf_cnt), STATS ? 32'(exp_uf_cnt) : 32'd0);
    chk("ovf_cnt_rand", 32'(ovf_cnt), 32'd0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    drive(8'h18, 8'b00111_000);
    drive(8'hE0, 8'b11000_000);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    sb.delete();
    exp_uf_cnt = 0;
    exp_ovf_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_uf_cnt", 32'(uf_cnt), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_no_stale", 32'(out_valid), 32'd0);
    end
    drive(8'h1C, 8'b01000_000);
    wait_drain("drain_postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
